// File: rtl/instr_fetch.sv
// Instruction fetch with prefetch FIFO; FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect fault.
// Latency: a word accepted at edge N is presented to decode after edge N (one registered stage).
// Backpressure: requests stop while the FIFO would be full; a decode stall holds the head entry.

module fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             wr_vld,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic             rd_rdy,
   output logic             rd_vld,
   output logic [WIDTH-1:0] rd_dat,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign rd_vld = (count != '0);
   assign do_wr  = wr_vld && (count != CW'(DEPTH));
   assign do_rd  = rd_rdy && rd_vld;
   assign rd_dat = mem[rd_ptr];

   // Storage is cleared on reset so the head reads as zero before the first push.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            mem[wr_ptr] <= wr_dat;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_wr) - CW'(do_rd);
      end
   end
endmodule

module instr_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        fetch_valid,
   output logic [31:0] fetch_instr,
   output logic [31:0] fetch_pc,
   input  logic        dec_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        fetch_fault
);
   localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

   state_t        state;
   state_t        state_next;
   logic [31:0]   pc;
   logic [31:0]   pc_next;
   logic [31:0]   req_addr;
   logic [31:0]   redir_tgt;
   logic [CW-1:0] count;
   logic [CW-1:0] count_after;
   logic          push;
   logic          pop;
   logic          fault_q;
   logic          redir_bad;
   entry_t        wr_entry;
   entry_t        head;

   assign mem_valid   = (state == REQ) || (state == DISCARD);
   assign mem_addr    = req_addr;
   assign fetch_instr = head.instr;
   assign fetch_pc    = head.pc;
   assign fetch_fault = fault_q;

   // A redirect flushes the FIFO, so it suppresses both the push and the pop of its cycle.
   assign push        = mem_valid && mem_ready && (state == REQ) && !redirect;
   assign pop         = fetch_valid && dec_ready && !redirect;
   assign count_after = count + CW'(push) - CW'(pop);
   assign redir_tgt   = redirect_pc & ~32'd3;
   assign wr_entry    = '{pc: req_addr, instr: mem_rdata};

   fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .flush  (redirect),
      .wr_vld (push),
      .wr_dat (wr_entry),
      .rd_rdy (pop),
      .rd_vld (fetch_valid),
      .rd_dat (head),
      .count  (count)
   );

`ifdef FETCH_MISALIGN_TRAP_EN
   assign redir_bad = (redirect_pc[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (reset)         fault_q <= 1'b0;
      else if (redirect) fault_q <= redir_bad;
   end
`else
   assign redir_bad = 1'b0;
   assign fault_q   = 1'b0;
`endif

   always_comb begin
      state_next = state;
      pc_next    = pc;
      case (state)
         IDLE:    if (!fault_q && (count_after < DEPTH_C)) state_next = REQ;
         REQ:     if (mem_ready && (count_after >= DEPTH_C)) state_next = IDLE;
         DISCARD: if (mem_ready) state_next = fault_q ? IDLE : REQ;
         default: state_next = IDLE;
      endcase
      if (push) pc_next = pc + 32'd4;
      // An unanswered request must still complete, so its response is dropped in DISCARD.
      if (redirect) begin
         pc_next = redir_tgt;
         if (mem_valid && !mem_ready) state_next = DISCARD;
         else if (redir_bad)          state_next = IDLE;
         else                         state_next = REQ;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         req_addr <= RESET_PC;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         if (state_next != DISCARD) req_addr <= pc_next;
      end
   end

   a_req_held: assert property (@(posedge clk) disable iff (reset)
      (mem_valid && !mem_ready) |=> (mem_valid && $stable(mem_addr)));
   a_addr_aligned: assert property (@(posedge clk) disable iff (reset)
      (mem_addr[1:0] == 2'b00));
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: cycle-exact vector table, hand-written redirect sequences,
// and a scoreboard fed at request acceptance and drained at decode handshakes.

module tb_instr_fetch;
   logic        clk = 1'b0;
   logic        reset;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        fetch_valid;
   logic [31:0] fetch_instr;
   logic [31:0] fetch_pc;
   logic        dec_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        fetch_fault;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        rst;
      logic        mr;
      logic        dr;
      logic        mv;
      logic [31:0] addr;
      logic        achk;
      logic        fv;
      logic [31:0] fpc;
   } vec_t;

   vec_t tbl [14];

   logic [31:0] sbq [$];
   logic [31:0] m_pc    = 32'h0;
   logic        m_disc  = 1'b0;
   logic        m_fault = 1'b0;

   instr_fetch dut (
      .clk         (clk),
      .reset       (reset),
      .mem_valid   (mem_valid),
      .mem_addr    (mem_addr),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .fetch_valid (fetch_valid),
      .fetch_instr (fetch_instr),
      .fetch_pc    (fetch_pc),
      .dec_ready   (dec_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .fetch_fault (fetch_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   assign mem_rdata = word_of(mem_addr);

   function automatic vec_t mk(input logic rst, input logic mr, input logic dr, input logic mv,
                               input logic [31:0] addr, input logic achk, input logic fv,
                               input logic [31:0] fpc);
      vec_t v;
      v.rst = rst; v.mr = mr; v.dr = dr; v.mv = mv;
      v.addr = addr; v.achk = achk; v.fv = fv; v.fpc = fpc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: tracks the expected fetch PC, pending discards, the fault flag
   // and the FIFO contents; decisions are taken on the stable pre-edge values.
   always @(negedge clk) begin
      if (reset) begin
         sbq.delete();
         m_pc    = 32'h0;
         m_disc  = 1'b0;
         m_fault = 1'b0;
      end else begin
         chk("sb_fault", 32'(fetch_fault), 32'(m_fault));
         chk("sb_valid", 32'(fetch_valid), 32'(sbq.size() != 0));
         if (m_fault && !m_disc) chk("sb_parked", 32'(mem_valid), 32'd0);
         if (redirect) begin
            m_disc = mem_valid && !mem_ready;
            sbq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
            m_fault = (redirect_pc[1:0] != 2'b00);
`endif
            m_pc = redirect_pc & 32'hFFFF_FFFC;
         end else begin
            if (fetch_valid && dec_ready) begin
               if (sbq.size() == 0) begin
                  chk("sb_underflow", 32'(sbq.size()), 32'd1);
               end else begin
                  logic [31:0] e;
                  e = sbq.pop_front();
                  chk("sb_pc", fetch_pc, e);
                  chk("sb_instr", fetch_instr, word_of(e));
               end
            end
            if (mem_valid && mem_ready) begin
               if (m_disc) begin
                  m_disc = 1'b0;
               end else begin
                  chk("sb_req_addr", mem_addr, m_pc);
                  sbq.push_back(m_pc);
                  m_pc = m_pc + 32'd4;
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset       = 1'b1;
      mem_ready   = 1'b1;
      dec_ready   = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;

      // Streaming from reset, then a stalled decode filling the FIFO and one pop.
      tbl[0]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      tbl[1]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      tbl[2]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      tbl[3]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
      tbl[4]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h4, 1'b1, 1'b1, 32'h0);
      tbl[5]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h8, 1'b1, 1'b1, 32'h4);
      tbl[6]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      tbl[7]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
      tbl[9]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h4, 1'b1, 1'b1, 32'h0);
      tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
      tbl[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
      tbl[12] = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h8, 1'b1, 1'b1, 32'h4);
      tbl[13] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 1'b1, 1'b1, 32'h4);

      for (int i = 0; i < 14; i++) begin
         reset     = tbl[i].rst;
         mem_ready = tbl[i].mr;
         dec_ready = tbl[i].dr;
         step();
         chk($sformatf("tbl%0d_mem_valid", i), 32'(mem_valid), 32'(tbl[i].mv));
         if (tbl[i].achk) chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].addr);
         chk($sformatf("tbl%0d_fetch_valid", i), 32'(fetch_valid), 32'(tbl[i].fv));
         if (tbl[i].fv || tbl[i].rst) begin
            chk($sformatf("tbl%0d_fetch_pc", i), fetch_pc, tbl[i].fpc);
            chk($sformatf("tbl%0d_fetch_instr", i), fetch_instr,
                tbl[i].fv ? word_of(tbl[i].fpc) : 32'h0);
         end
         chk($sformatf("tbl%0d_fault", i), 32'(fetch_fault), 32'd0);
      end

      // Redirect while a request is pending: the old response is dropped.
      reset     = 1'b1;
      mem_ready = 1'b1;
      dec_ready = 1'b1;
      step();
      step();
      reset = 1'b0;
      n = 0;
      while (!(mem_valid && mem_addr == 32'h10) && n < 30) begin
         step();
         n++;
      end
      chk("t3_reach_0x10", mem_addr, 32'h10);
      mem_ready = 1'b0;
      step();
      chk("t3_hold_addr", mem_addr, 32'h10);
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      chk("t3_disc_valid", 32'(mem_valid), 32'd1);
      chk("t3_disc_addr", mem_addr, 32'h10);
      chk("t3_flushed", 32'(fetch_valid), 32'd0);
      step();
      chk("t3_disc_addr2", mem_addr, 32'h10);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      chk("t3_new_addr", mem_addr, 32'h100);
      chk("t3_dropped", 32'(fetch_valid), 32'd0);
      step();
      chk("t3_still_empty", 32'(fetch_valid), 32'd0);
      mem_ready = 1'b1;
      step();
      chk("t3_first_valid", 32'(fetch_valid), 32'd1);
      chk("t3_first_pc", fetch_pc, 32'h100);

      // Redirect coinciding with an accepted response and a pop.
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      step();
      redirect = 1'b0;
      chk("t4_empty", 32'(fetch_valid), 32'd0);
      chk("t4_addr", mem_addr, 32'h200);
      step();
      chk("t4_pc", fetch_pc, 32'h200);

      // PC wrap at the top of the address space.
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      chk("t5_top_addr", mem_addr, 32'hFFFF_FFFC);
      step();
      chk("t5_wrap_addr", mem_addr, 32'h0);
      chk("t5_top_pc", fetch_pc, 32'hFFFF_FFFC);
      step();
      chk("t5_wrap_pc", fetch_pc, 32'h0);

      // Misaligned redirect.
      redirect    = 1'b1;
      redirect_pc = 32'h102;
      step();
      redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("t6_fault_set", 32'(fetch_fault), 32'd1);
      chk("t6_parked", 32'(mem_valid), 32'd0);
      step();
      chk("t6_parked2", 32'(mem_valid), 32'd0);
      chk("t6_no_valid", 32'(fetch_valid), 32'd0);
      redirect    = 1'b1;
      redirect_pc = 32'h104;
      step();
      redirect = 1'b0;
      chk("t6_fault_clr", 32'(fetch_fault), 32'd0);
      chk("t6_resume_addr", mem_addr, 32'h104);
      mem_ready   = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h106;
      step();
      redirect = 1'b0;
      chk("t6_disc_addr", mem_addr, 32'h104);
      chk("t6_disc_fault", 32'(fetch_fault), 32'd1);
      mem_ready = 1'b1;
      step();
      chk("t6_disc_parked", 32'(mem_valid), 32'd0);
      redirect    = 1'b1;
      redirect_pc = 32'h108;
      step();
      redirect = 1'b0;
      chk("t6_resume2_addr", mem_addr, 32'h108);
      chk("t6_resume2_fault", 32'(fetch_fault), 32'd0);
`else
      chk("t6_aligned_addr", mem_addr, 32'h100);
      chk("t6_no_fault", 32'(fetch_fault), 32'd0);
      chk("t6_valid", 32'(mem_valid), 32'd1);
`endif

      // Random traffic checked by the scoreboard.
      for (int i = 0; i < 400; i++) begin
         mem_ready   = ($urandom_range(0, 3) != 0);
         dec_ready   = ($urandom_range(0, 2) != 0);
         redirect    = ($urandom_range(0, 24) == 0);
         redirect_pc = $urandom & 32'hFFFF_FFFC;
         step();
      end
      redirect = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
